seven_seg_scan_ctrl: RTL



---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/bcd_seg_decode.sv | 38 +++
 rtl/seven_seg_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment-code constants for the seven-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seven_seg_pkg;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1111110;
   localparam seg_t SEG_1     = 7'b0110000;
   localparam seg_t SEG_2     = 7'b1101101;
   localparam seg_t SEG_3     = 7'b1111001;
   localparam seg_t SEG_4     = 7'b0110011;
   localparam seg_t SEG_5     = 7'b1011011;
   localparam seg_t SEG_6     = 7'b1011111;
   localparam seg_t SEG_7     = 7'b1110000;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1111011;
   localparam seg_t SEG_BLANK = '0;
   localparam seg_t SEG_ALL   = '1;
endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational 7447-style BCD to seven-segment decoder; codes 10-15 are dark.
// rbo_n goes low whenever the digit is dark because of bi_n or ripple blanking.
module bcd_seg_decode
   import seven_seg_pkg::*;
(
   input  logic       lt_n,
   input  logic       bi_n,
   input  logic       rbi_n,
   input  logic [3:0] code,
   output logic [6:0] seg,
   output logic       rbo_n
);
   always_comb begin
      seg   = SEG_BLANK;
      rbo_n = 1'b1;
      if (!bi_n) begin
         rbo_n = 1'b0;
      end else if (!lt_n) begin
         seg = SEG_ALL;
      end else if (!rbi_n && code == 4'd0) begin
         rbo_n = 1'b0;
      end else begin
         case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with a double-buffered
// BCD word, load/ready handshake, lamp test, blanking and leading-zero suppression.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   output logic                    ready,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    lt_n,
   input  logic                    bi_n,
   input  logic                    rbi_en,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic [6:0]              seg
);
   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned DW = 4 * NUM_DIGITS;

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DW-1:0]         disp_q, disp_d;
   logic [DW-1:0]         pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
   seg_t                  seg_q, seg_d;

   logic       slot_end, frame_end;
   logic       upper_nz, dec_rbi_n, dec_rbo_n;
   logic [3:0] cur_code;
   seg_t       dec_seg;

   assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

   always_comb begin
      presc_d    = slot_end ? '0 : presc_q + 1'b1;
      idx_d      = idx_q;
      if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;

      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      // Transfer and capture are exclusive: capture needs pending empty, transfer needs it full.
      if (frame_end && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end else if (load && !pend_vld_q) begin
         pend_d     = bcd_in;
         pend_vld_d = 1'b1;
      end
   end

   // Current digit code and whether any more-significant digit is non-zero.
   always_comb begin
      cur_code = '0;
      upper_nz = 1'b0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         if (IW'(j) == idx_q) cur_code = disp_q[4*j +: 4];
         if (IW'(j) > idx_q && disp_q[4*j +: 4] != 4'd0) upper_nz = 1'b1;
      end
      dec_rbi_n = !(rbi_en && idx_q != '0 && !upper_nz);
   end

   bcd_seg_decode u_decode (
      .lt_n  (lt_n),
      .bi_n  (bi_n),
      .rbi_n (dec_rbi_n),
      .code  (cur_code),
      .seg   (dec_seg),
      .rbo_n (dec_rbo_n)
   );

   always_comb begin
      dig_en_d = '0;
      if (bi_n && presc_q >= PW'(BLANK_CYC)) dig_en_d[idx_q] = 1'b1;
      seg_d = dec_rbo_n ? dec_seg : SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         dig_en_q   <= '0;
         seg_q      <= SEG_BLANK;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         dig_en_q   <= dig_en_d;
         seg_q      <= seg_d;
      end
   end

   assign ready  = !pend_vld_q;
   assign dig_en = dig_en_q;
   assign seg    = seg_q;
endmodule
